// File: rtl/cpu_uart_pkg.sv
// cpu_uart shared types: FSM state encoding, register offsets, STATUS bits.
// Optional loopback build: define CPU_UART_LOOPBACK_EN.
package cpu_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic REG_STATUS = 1'b0;
  localparam logic REG_DATA   = 1'b1;

  localparam int STS_TX_FULL   = 0;
  localparam int STS_RX_VALID  = 1;
  localparam int STS_RX_OVR    = 2;
  localparam int STS_FRAME_ERR = 3;
  localparam int STS_TX_BUSY   = 4;
  localparam int STS_LOOPBACK  = 8;

endpackage

// File: rtl/cpu_uart_if.sv
// cpu_uart CPU bus: one-cycle request strobe, ack one cycle later.
// rdata is only meaningful while ack is high.
interface cpu_uart_if;
  logic        request;
  logic        ack;
  logic [3:0]  wmask;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output request, wmask, address, wdata,
    input  ack, rdata
  );

  modport slave (
    input  request, wmask, address, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/cpu_uart_fifo.sv
// cpu_uart byte FIFO, fall-through read port, extra pointer MSB for full.
// A pop frees the slot first, so a push into a full FIFO with pop succeeds.
module cpu_uart_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]            mem_q [DEPTH];
  logic                  do_push, do_pop;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;

  assign wr_idx  = wr_ptr_q[DEPTH_LOG2-1:0];
  assign rd_idx  = rd_ptr_q[DEPTH_LOG2-1:0];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2])
                && (wr_idx == rd_idx);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_idx];

  // Pointer advance on accepted push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage, no reset needed: only read behind the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= wdata;
  end

endmodule

// File: rtl/cpu_uart.sv
// cpu_uart: bus-slave 8N1 UART with TX/RX byte FIFOs.
// Optional: CPU_UART_LOOPBACK_EN adds STATUS bit8 routing txd into RX.
module cpu_uart
  import cpu_uart_pkg::*;
#(
  parameter int CLK_DIV         = 100,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic     clk,
  input  logic     reset,
  cpu_uart_if.slave bus,
  output logic     uart_txd,
  input  logic     uart_rxd
);

  localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

  logic        is_wr, rd_req, wr_req;
  logic        tx_push, rx_pop, clr_ovr, clr_fe;
  logic [7:0]  tx_rdata, rx_rdata;
  logic        tx_full, tx_empty, tx_pop;
  logic        rx_full, rx_empty, rx_push;
  logic        ovr_set, fe_set;
  logic        ovr_q, ovr_d, fe_q, fe_d;
  logic        ack_q;
  logic [31:0] rdata_q, rdata_d, status;
  logic        loopback, rx_pin;

  uart_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_shreg_q, tx_shreg_d;

  uart_state_e rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_shreg_q, rx_shreg_d;
  logic        rx_wait_q, rx_wait_d;
  logic        rx_sync1_q, rx_sync2_q, rx_prev_q;

  logic unused_bits;
  assign unused_bits = ^{bus.address[31:3], bus.address[1:0],
                         bus.wdata[31:8], bus.wmask[3:1]};

  assign is_wr   = (bus.wmask != 4'h0);
  assign wr_req  = bus.request && is_wr;
  assign rd_req  = bus.request && !is_wr;
  assign tx_push = wr_req && (bus.address[2] == REG_DATA)
                && bus.wmask[0];
  assign rx_pop  = rd_req && (bus.address[2] == REG_DATA)
                && !rx_empty;
  assign clr_ovr = wr_req && (bus.address[2] == REG_STATUS)
                && bus.wdata[STS_RX_OVR];
  assign clr_fe  = wr_req && (bus.address[2] == REG_STATUS)
                && bus.wdata[STS_FRAME_ERR];
  assign ovr_set = rx_push && rx_full && !rx_pop;

`ifdef CPU_UART_LOOPBACK_EN
  logic lb_q, lb_d;

  // Loopback enable bit written through STATUS
  always_comb begin
    lb_d = lb_q;
    if (wr_req && (bus.address[2] == REG_STATUS))
      lb_d = bus.wdata[STS_LOOPBACK];
  end

  // Loopback enable register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lb_q <= 1'b0;
    else       lb_q <= lb_d;
  end

  assign loopback = lb_q;
  assign rx_pin   = lb_q ? uart_txd : uart_rxd;
`else
  assign loopback = 1'b0;
  assign rx_pin   = uart_rxd;
`endif

  cpu_uart_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .wdata (bus.wdata[7:0]),
    .pop   (tx_pop),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty)
  );

  cpu_uart_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .wdata (rx_shreg_q),
    .pop   (rx_pop),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // STATUS word, read data and sticky flags (set beats clear)
  always_comb begin
    status                = '0;
    status[STS_TX_FULL]   = tx_full;
    status[STS_RX_VALID]  = !rx_empty;
    status[STS_RX_OVR]    = ovr_q;
    status[STS_FRAME_ERR] = fe_q;
    status[STS_TX_BUSY]   = !tx_empty || (tx_state_q != ST_IDLE);
    status[STS_LOOPBACK]  = loopback;
    rdata_d = '0;
    if (rd_req) begin
      if (bus.address[2] == REG_DATA)
        rdata_d = rx_empty ? 32'h0 : {24'h0, rx_rdata};
      else
        rdata_d = status;
    end
    ovr_d = ovr_q;
    fe_d  = fe_q;
    if (clr_ovr) ovr_d = 1'b0;
    if (clr_fe)  fe_d  = 1'b0;
    if (ovr_set) ovr_d = 1'b1;
    if (fe_set)  fe_d  = 1'b1;
  end

  // Bus response and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      ack_q   <= bus.request;
      rdata_q <= rdata_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

  // TX FSM: start, 8 data bits LSB first, stop; chains frames with no gap
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shreg_d = tx_shreg_q;
    tx_pop     = 1'b0;
    uart_txd   = 1'b1;
    unique case (tx_state_q)
      ST_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shreg_d = tx_rdata;
          tx_cnt_d   = '0;
          tx_state_d = ST_START;
        end
      end
      ST_START: begin
        uart_txd = 1'b0;
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = ST_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        uart_txd = tx_shreg_q[tx_idx_q];
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          tx_idx_d = tx_idx_q + 3'd1;
          if (tx_idx_q == 3'd7) tx_state_d = ST_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_IDLE;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shreg_d = tx_rdata;
            tx_state_d = ST_START;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // TX FSM registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shreg_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shreg_q <= tx_shreg_d;
    end
  end

  // RX FSM: mid-bit sampling; bad stop flags and waits for idle line
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shreg_d = rx_shreg_q;
    rx_wait_d  = rx_wait_q;
    rx_push    = 1'b0;
    fe_set     = 1'b0;
    unique case (rx_state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_sync2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_START;
        end
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_sync2_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shreg_d = {rx_sync2_q, rx_shreg_q[7:1]};
          rx_idx_d   = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) rx_state_d = ST_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (rx_wait_q) begin
          if (rx_sync2_q) begin
            rx_wait_d  = 1'b0;
            rx_state_d = ST_IDLE;
          end
        end else if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync2_q) begin
            rx_push    = 1'b1;
            rx_state_d = ST_IDLE;
          end else begin
            fe_set    = 1'b1;
            rx_wait_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // RX synchroniser, edge history and FSM registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shreg_q <= '0;
      rx_wait_q  <= 1'b0;
    end else begin
      rx_sync1_q <= rx_pin;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shreg_q <= rx_shreg_d;
      rx_wait_q  <= rx_wait_d;
    end
  end

endmodule
